// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data-memory access with stall,
// load extension, misalignment detection and bus timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_MemRead,
  input  logic               mem_MemWrite,
  input  logic [2:0]         mem_funct3,
  input  logic [31:0]        mem_alu_result,
  input  logic [31:0]        mem_write_data,
  mem_access_unit_if.master  dmem,
  output logic               mem_stall,
  output logic [31:0]        mem_load_data,
  output logic               mem_load_valid,
  output logic               mem_misaligned,
  output logic               mem_bus_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      f3_q;
  logic [1:0]      alo_q;
  logic            ld_q;

  logic            access;
  logic            fault;
  logic            timeout;
  logic [1:0]      alo;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ext;

  assign access  = mem_MemRead | mem_MemWrite;
  assign alo     = mem_alu_result[1:0];
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);

  always_comb begin
    fault = 1'b0;
    case (mem_funct3)
      3'd0, 3'd4: fault = 1'b0;
      3'd1, 3'd5: fault = alo[0];
      3'd2:       fault = |alo;
      default:    fault = 1'b1;
    endcase
  end

  always_comb begin
    be_c    = 4'hF;
    wdata_c = mem_write_data;
    case (mem_funct3[1:0])
      2'd0: begin
        be_c    = 4'b0001 << alo;
        wdata_c = {4{mem_write_data[7:0]}};
      end
      2'd1: begin
        be_c    = alo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the offset/funct3 latched at request time.
  always_comb begin
    rbyte = 8'h00;
    unique case (1'b1)
      alo_q == 2'd0: rbyte = dmem.dmem_rdata[7:0];
      alo_q == 2'd1: rbyte = dmem.dmem_rdata[15:8];
      alo_q == 2'd2: rbyte = dmem.dmem_rdata[23:16];
      alo_q == 2'd3: rbyte = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    rhalf = alo_q[1] ? dmem.dmem_rdata[31:16]
                     : dmem.dmem_rdata[15:0];
    case (f3_q)
      3'd0:    ext = {{24{rbyte[7]}}, rbyte};
      3'd1:    ext = {{16{rhalf[15]}}, rhalf};
      3'd4:    ext = {24'h0, rbyte};
      3'd5:    ext = {16'h0, rhalf};
      default: ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (access && !fault) state_nxt = S_WAIT;
      S_WAIT:
        if (dmem.dmem_ack || timeout) state_nxt = S_DONE;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  assign mem_stall = (state == S_IDLE && access && !fault)
                   || state == S_WAIT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      cnt             <= '0;
      f3_q            <= '0;
      alo_q           <= '0;
      ld_q            <= 1'b0;
      mem_load_data   <= '0;
      mem_load_valid  <= 1'b0;
      mem_misaligned  <= 1'b0;
      mem_bus_error   <= 1'b0;
    end else begin
      mem_load_valid <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_bus_error  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access && fault) begin
            mem_misaligned <= 1'b1;
            mem_load_data  <= '0;
          end else if (access) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_MemWrite;
            dmem.dmem_addr  <= {mem_alu_result[31:2], 2'b00};
            dmem.dmem_be    <= be_c;
            dmem.dmem_wdata <= wdata_c;
            cnt             <= '0;
            f3_q            <= mem_funct3;
            alo_q           <= alo;
            ld_q            <= !mem_MemWrite;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            if (ld_q) begin
              mem_load_data  <= ext;
              mem_load_valid <= 1'b1;
            end
          end else if (timeout) begin
            dmem.dmem_req <= 1'b0;
            mem_load_data <= '0;
            mem_bus_error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, faults,
// timeout and reset abort against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misal;
  logic        berr;

  int total = 0;
  int bad = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_MemRead(rd),
    .mem_MemWrite(wr),
    .mem_funct3(f3),
    .mem_alu_result(addr),
    .mem_write_data(wd),
    .dmem(bus.master),
    .mem_stall(stall),
    .mem_load_data(ld_data),
    .mem_load_valid(ld_valid),
    .mem_misaligned(misal),
    .mem_bus_error(berr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access acked on its first WAIT cycle; starts and ends at a negedge.
  task automatic xact(input string tag,
                      input logic r, input logic w,
                      input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rdat,
                      input logic [31:0] e_addr,
                      input logic [3:0] e_be,
                      input logic [31:0] e_wdata,
                      input logic [31:0] e_ld);
    logic is_ld;
    is_ld = r && !w;
    rd = r; wr = w; f3 = f; addr = a; wd = d;
    #1 chk({tag, " stall idle"}, 32'(stall), 32'd1);
    @(negedge clk);
    chk({tag, " req"}, 32'(bus.dmem_req), 32'd1);
    chk({tag, " we"}, 32'(bus.dmem_we), 32'(w));
    chk({tag, " addr"}, bus.dmem_addr, e_addr);
    chk({tag, " stall wait"}, 32'(stall), 32'd1);
    if (w) begin
      chk({tag, " be"}, 32'(bus.dmem_be), 32'(e_be));
      chk({tag, " wdata"}, bus.dmem_wdata, e_wdata);
    end
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = rdat;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk({tag, " req done"}, 32'(bus.dmem_req), 32'd0);
    chk({tag, " stall done"}, 32'(stall), 32'd0);
    chk({tag, " valid"}, 32'(ld_valid), 32'(is_ld));
    if (is_ld) chk({tag, " data"}, ld_data, e_ld);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk({tag, " valid drop"}, 32'(ld_valid), 32'd0);
  endtask

  task automatic misal_case(input string tag,
                            input logic r, input logic w,
                            input logic [2:0] f,
                            input logic [31:0] a);
    rd = r; wr = w; f3 = f; addr = a;
    #1 chk({tag, " stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({tag, " req"}, 32'(bus.dmem_req), 32'd0);
    chk({tag, " pulse"}, 32'(misal), 32'd1);
    chk({tag, " data"}, ld_data, 32'd0);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk({tag, " pulse drop"}, 32'(misal), 32'd0);
  endtask

  initial begin
    int n;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst req", 32'(bus.dmem_req), 32'd0);
    chk("rst data", ld_data, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst valid", 32'(ld_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    xact("lw", 1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF,
         32'h100, 4'hF, 0, 32'hDEADBEEF);
    chk("ld hold", ld_data, 32'hDEADBEEF);
    xact("lb", 1, 0, 3'd0, 32'h103, 0, 32'h80112233,
         32'h100, 4'h8, 0, 32'hFFFFFF80);
    xact("lbu", 1, 0, 3'd4, 32'h103, 0, 32'h80112233,
         32'h100, 4'h8, 0, 32'h00000080);
    xact("lh", 1, 0, 3'd1, 32'h102, 0, 32'h80112233,
         32'h100, 4'hC, 0, 32'hFFFF8011);
    xact("lhu", 1, 0, 3'd5, 32'h100, 0, 32'h80112233,
         32'h100, 4'h3, 0, 32'h00002233);
    xact("lb1", 1, 0, 3'd0, 32'h101, 0, 32'h80112233,
         32'h100, 4'h2, 0, 32'h00000022);
    xact("sh", 0, 1, 3'd1, 32'h0A, 32'h0000ABCD, 0,
         32'h08, 4'b1100, 32'hABCDABCD, 0);
    xact("sb", 0, 1, 3'd0, 32'h05, 32'h12345677, 0,
         32'h04, 4'b0010, 32'h77777777, 0);
    xact("sw", 0, 1, 3'd2, 32'h10, 32'hCAFEF00D, 0,
         32'h10, 4'hF, 32'hCAFEF00D, 0);
    xact("rdwr", 1, 1, 3'd0, 32'h22, 32'h000000A5, 0,
         32'h20, 4'b0100, 32'hA5A5A5A5, 0);
    chk("st keeps data", ld_data, 32'h00000022);

    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h55555555;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("idle ack valid", 32'(ld_valid), 32'd0);
    chk("idle ack data", ld_data, 32'h00000022);

    misal_case("mis lw", 1, 0, 3'd2, 32'h102);
    xact("lw2", 1, 0, 3'd2, 32'h104, 0, 32'h01020304,
         32'h104, 4'hF, 0, 32'h01020304);
    misal_case("mis f3", 1, 0, 3'd3, 32'h100);
    misal_case("mis sh", 0, 1, 3'd1, 32'h3);
    misal_case("mis f7", 1, 0, 3'd7, 32'h0);

    xact("lw3", 1, 0, 3'd2, 32'h108, 0, 32'h0BADF00D,
         32'h108, 4'hF, 0, 32'h0BADF00D);
    rd = 1'b1; f3 = 3'd2; addr = 32'h200;
    @(negedge clk);
    n = 0;
    while (bus.dmem_req && n < 40) begin
      n++;
      if (!stall) chk("to stall", 32'(stall), 32'd1);
      @(negedge clk);
    end
    chk("to req cycles", n, 16);
    chk("to berr", 32'(berr), 32'd1);
    chk("to data", ld_data, 32'd0);
    chk("to valid", 32'(ld_valid), 32'd0);
    chk("to stall done", 32'(stall), 32'd0);
    rd = 1'b0;
    @(negedge clk);
    chk("to berr drop", 32'(berr), 32'd0);
    xact("post to", 1, 0, 3'd5, 32'h202, 0, 32'hFACE0000,
         32'h200, 4'hC, 0, 32'h0000FACE);

    rd = 1'b1; f3 = 3'd2; addr = 32'h300;
    @(negedge clk);
    chk("rw req", 32'(bus.dmem_req), 32'd1);
    reset = 1'b1;
    rd = 1'b0;
    #1;
    chk("rw req rst", 32'(bus.dmem_req), 32'd0);
    chk("rw stall rst", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h12345678;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("rw late valid", 32'(ld_valid), 32'd0);
    chk("rw late data", ld_data, 32'd0);
    chk("rw late req", 32'(bus.dmem_req), 32'd0);
    xact("post rst", 1, 0, 3'd0, 32'h300, 0, 32'h0000007F,
         32'h300, 4'h1, 0, 32'h0000007F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
